// File: rtl/comp_pair_serializer_pkg.sv
// Shared definitions for the pair-to-byte serializer: default data width and
// the output-stage state encoding.
package comp_pair_serializer_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSendX = 2'd1,
        StSendY = 2'd2
    } state_e;

endpackage

// File: rtl/comp_pair_serializer_pair_fifo.sv
// Pair FIFO: Depth entries of {x, y}, with push/pop/synchronous flush and an
// occupancy count that spans 0..Depth.
module comp_pair_serializer_pair_fifo #(
    parameter int unsigned Width = 16,
    parameter int unsigned Depth = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           rdata_o,
    output logic [$clog2(Depth):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth) + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_en, pop_en;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Guard against overflow/underflow even if the caller misbehaves.
    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push_en, pop_en})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/comp_pair_serializer.sv
// Accepts (x, y) pairs over valid/ready, buffers them, and re-emits each pair
// as two byte beats (x then y) from a registered holding stage.
module comp_pair_serializer
    import comp_pair_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   io_flush,
    input  logic                   io_in_valid,
    output logic                   io_in_ready,
    input  logic [WIDTH-1:0]       io_in_x,
    input  logic [WIDTH-1:0]       io_in_y,
    output logic                   io_out_valid,
    input  logic                   io_out_ready,
    output logic [WIDTH-1:0]       io_out_data,
    output logic                   io_out_sel,
    output logic [$clog2(DEPTH):0] io_count
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   hold_x_q, hold_x_d;
    logic [WIDTH-1:0]   hold_y_q, hold_y_d;
    logic               fifo_push, fifo_pop;
    logic               fifo_full, fifo_empty;
    logic [2*WIDTH-1:0] fifo_rdata;

    // Ready depends only on registered occupancy, never on io_out_ready.
    assign io_in_ready = ~fifo_full;
    assign fifo_push   = io_in_valid & io_in_ready;

    comp_pair_serializer_pair_fifo #(
        .Width (2 * WIDTH),
        .Depth (DEPTH)
    ) u_pair_fifo (
        .clk_i   (clock),
        .rst_ni  (reset),
        .flush_i (io_flush),
        .push_i  (fifo_push),
        .wdata_i ({io_in_x, io_in_y}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (io_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        hold_x_d = hold_x_q;
        hold_y_d = hold_y_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    {hold_x_d, hold_y_d} = fifo_rdata;
                    fifo_pop             = 1'b1;
                    state_d              = StSendX;
                end
            end
            StSendX: begin
                if (io_out_ready) begin
                    state_d = StSendY;
                end
            end
            StSendY: begin
                if (io_out_ready) begin
                    if (!fifo_empty) begin
                        {hold_x_d, hold_y_d} = fifo_rdata;
                        fifo_pop             = 1'b1;
                        state_d              = StSendX;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (io_flush) begin
            state_d  = StIdle;
            fifo_pop = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            hold_x_q <= '0;
            hold_y_q <= '0;
        end else begin
            state_q  <= state_d;
            hold_x_q <= hold_x_d;
            hold_y_q <= hold_y_d;
        end
    end

    assign io_out_valid = (state_q != StIdle);
    assign io_out_sel   = (state_q == StSendY);
    assign io_out_data  = io_out_sel ? hold_y_q : hold_x_q;

endmodule

// File: tb/tb_comp_pair_serializer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// byte-queue scoreboard of the expected output stream.
module tb_comp_pair_serializer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 2;

    logic             clock;
    logic             reset;
    logic             io_flush;
    logic             io_in_valid;
    logic             io_in_ready;
    logic [WIDTH-1:0] io_in_x;
    logic [WIDTH-1:0] io_in_y;
    logic             io_out_valid;
    logic             io_out_ready;
    logic [WIDTH-1:0] io_out_data;
    logic             io_out_sel;
    logic [1:0]       io_count;

    int n_checks = 0;
    int n_errors = 0;

    // Expected byte stream: {sel, data} in delivery order.
    logic [8:0] exp_q[$];
    logic       prev_hold;
    logic [7:0] prev_data;
    logic       prev_sel;

    comp_pair_serializer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .io_flush     (io_flush),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_in_x      (io_in_x),
        .io_in_y      (io_in_y),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_data  (io_out_data),
        .io_out_sel   (io_out_sel),
        .io_count     (io_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Runs at the falling edge, with this cycle's inputs already applied.
    task automatic monitor();
        int pairs;
        logic [8:0] e;
        if (!reset) begin
            exp_q.delete();
            prev_hold = 1'b0;
            return;
        end
        pairs = (exp_q.size() + 1) / 2;
        check_eq("occupancy", 32'(io_count) + 32'(io_out_valid), 32'(pairs));
        if (pairs < int'(DEPTH)) check_eq("in_ready_free", 32'(io_in_ready), 32'd1);
        if (pairs > int'(DEPTH)) check_eq("in_ready_full", 32'(io_in_ready), 32'd0);
        if (prev_hold) begin
            check_eq("hold_valid", 32'(io_out_valid), 32'd1);
            check_eq("hold_data", 32'(io_out_data), 32'(prev_data));
            check_eq("hold_sel", 32'(io_out_sel), 32'(prev_sel));
        end
        if (io_out_valid && io_out_ready) begin
            check_eq("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("beat_data", 32'(io_out_data), 32'(e[7:0]));
                check_eq("beat_sel", 32'(io_out_sel), 32'(e[8]));
            end
        end
        if (io_flush) begin
            exp_q.delete();
        end else if (io_in_valid && io_in_ready) begin
            exp_q.push_back({1'b0, io_in_x});
            exp_q.push_back({1'b1, io_in_y});
        end
        prev_hold = io_out_valid && !io_out_ready && !io_flush;
        prev_data = io_out_data;
        prev_sel  = io_out_sel;
    endtask

    task automatic step();
        @(negedge clock);
        monitor();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int idx, beats, bubbles, cyc, accepted;
        bit seen, acc, saw_not_ready, saw_valid;
        logic [7:0] out_bytes [8];

        prev_hold    = 1'b0;
        prev_data    = '0;
        prev_sel     = 1'b0;
        reset        = 1'b0;
        io_flush     = 1'b0;
        io_in_valid  = 1'b0;
        io_in_x      = '0;
        io_in_y      = '0;
        io_out_ready = 1'b0;

        // Reset
        repeat (3) step();
        check_eq("rst_hold_valid", 32'(io_out_valid), 32'd0);
        reset = 1'b1;
        check_eq("rst_valid", 32'(io_out_valid), 32'd0);
        check_eq("rst_count", 32'(io_count), 32'd0);
        check_eq("rst_in_ready", 32'(io_in_ready), 32'd1);
        check_eq("rst_data", 32'(io_out_data), 32'd0);
        check_eq("rst_sel", 32'(io_out_sel), 32'd0);

        // Single pair and latency
        io_out_ready = 1'b1;
        io_in_x      = 8'h12;
        io_in_y      = 8'h34;
        io_in_valid  = 1'b1;
        step();
        io_in_valid = 1'b0;
        check_eq("single_not_yet", 32'(io_out_valid), 32'd0);
        check_eq("single_count1", 32'(io_count), 32'd1);
        step();
        check_eq("single_x_valid", 32'(io_out_valid), 32'd1);
        check_eq("single_x_data", 32'(io_out_data), 32'h12);
        check_eq("single_x_sel", 32'(io_out_sel), 32'd0);
        step();
        check_eq("single_y_valid", 32'(io_out_valid), 32'd1);
        check_eq("single_y_data", 32'(io_out_data), 32'h34);
        check_eq("single_y_sel", 32'(io_out_sel), 32'd1);
        step();
        check_eq("single_done", 32'(io_out_valid), 32'd0);

        // Streaming four pairs, consumer always ready
        idx = 0; beats = 0; bubbles = 0; cyc = 0; seen = 0; saw_not_ready = 0;
        while (beats < 8 && cyc < 60) begin
            if (idx < 4) begin
                io_in_valid = 1'b1;
                io_in_x     = 8'(2 * idx + 1);
                io_in_y     = 8'(2 * idx + 2);
            end else begin
                io_in_valid = 1'b0;
            end
            acc = io_in_valid && io_in_ready;
            if (io_in_valid && !io_in_ready) saw_not_ready = 1;
            if (io_out_valid) begin
                seen = 1;
                out_bytes[beats] = io_out_data;
                beats++;
            end else if (seen) begin
                bubbles++;
            end
            step();
            if (acc) idx++;
            cyc++;
        end
        io_in_valid = 1'b0;
        check_eq("stream_pairs_in", 32'(idx), 32'd4);
        check_eq("stream_beats", 32'(beats), 32'd8);
        check_eq("stream_bubbles", 32'(bubbles), 32'd0);
        check_eq("stream_backpressure", 32'(saw_not_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check_eq("stream_order", 32'(out_bytes[i]), 32'(i + 1));
        end
        check_eq("stream_idle", 32'(io_out_valid), 32'd0);

        // Backpressure: capacity is DEPTH + 1 pairs
        io_out_ready = 1'b0;
        accepted     = 0;
        for (int i = 0; i < 8; i++) begin
            io_in_valid = 1'b1;
            io_in_x     = 8'(8'hA0 + 2 * accepted);
            io_in_y     = 8'(8'hA1 + 2 * accepted);
            acc         = io_in_ready;
            step();
            if (acc) accepted++;
        end
        io_in_valid = 1'b0;
        check_eq("full_accepted", 32'(accepted), 32'd3);
        check_eq("full_count", 32'(io_count), 32'd2);
        check_eq("full_in_ready", 32'(io_in_ready), 32'd0);
        check_eq("full_valid", 32'(io_out_valid), 32'd1);
        check_eq("full_data", 32'(io_out_data), 32'hA0);
        io_out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 30) begin
            step();
            cyc++;
        end
        check_eq("full_drained", 32'(exp_q.size()), 32'd0);
        check_eq("full_idle", 32'(io_out_valid), 32'd0);

        // Flush with count = DEPTH while sending y
        io_out_ready = 1'b0;
        accepted     = 0;
        cyc          = 0;
        while (accepted < 3 && cyc < 20) begin
            io_in_valid = 1'b1;
            io_in_x     = 8'(8'hC0 + 2 * accepted);
            io_in_y     = 8'(8'hC1 + 2 * accepted);
            acc         = io_in_ready;
            step();
            if (acc) accepted++;
            cyc++;
        end
        io_in_valid  = 1'b0;
        io_out_ready = 1'b1;
        step();
        io_out_ready = 1'b0;
        check_eq("flush_pre_sel", 32'(io_out_sel), 32'd1);
        check_eq("flush_pre_count", 32'(io_count), 32'd2);
        io_flush    = 1'b1;
        io_in_valid = 1'b1;
        io_in_x     = 8'hEE;
        io_in_y     = 8'hEF;
        step();
        io_flush    = 1'b0;
        io_in_valid = 1'b0;
        check_eq("flush_valid", 32'(io_out_valid), 32'd0);
        check_eq("flush_count", 32'(io_count), 32'd0);
        check_eq("flush_in_ready", 32'(io_in_ready), 32'd1);
        // Flush drops a pair whose handshake completes in the same cycle
        io_flush    = 1'b1;
        io_in_valid = 1'b1;
        io_in_x     = 8'hDD;
        io_in_y     = 8'hDE;
        step();
        io_flush    = 1'b0;
        io_in_valid = 1'b0;
        check_eq("flush_push_dropped", 32'(io_count), 32'd0);
        io_out_ready = 1'b1;
        saw_valid    = 0;
        repeat (8) begin
            step();
            if (io_out_valid) saw_valid = 1;
        end
        check_eq("flush_no_beats", 32'(saw_valid), 32'd0);

        // Asynchronous reset during SEND_X
        io_out_ready = 1'b0;
        io_in_valid  = 1'b1;
        io_in_x      = 8'h5A;
        io_in_y      = 8'hA5;
        step();
        io_in_valid = 1'b0;
        cyc = 0;
        while (!io_out_valid && cyc < 10) begin
            step();
            cyc++;
        end
        check_eq("arst_sendx_reached", 32'(io_out_valid), 32'd1);
        #3;
        reset = 1'b0;
        #1;
        check_eq("arst_valid", 32'(io_out_valid), 32'd0);
        check_eq("arst_count", 32'(io_count), 32'd0);
        check_eq("arst_data", 32'(io_out_data), 32'd0);
        step();
        step();
        reset = 1'b1;
        check_eq("arst_release_valid", 32'(io_out_valid), 32'd0);
        check_eq("arst_release_ready", 32'(io_in_ready), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            io_in_valid  = 1'($urandom_range(0, 1));
            io_in_x      = 8'($urandom);
            io_in_y      = 8'($urandom);
            io_out_ready = ($urandom_range(0, 3) != 0);
            io_flush     = ($urandom_range(0, 31) == 0);
            step();
        end
        io_in_valid  = 1'b0;
        io_flush     = 1'b0;
        io_out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 30) begin
            step();
            cyc++;
        end
        check_eq("rand_drained", 32'(exp_q.size()), 32'd0);
        step();
        check_eq("rand_idle", 32'(io_out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
